// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and data access.
// One transaction in flight; data wins ties, and the RESP hand-off alternates masters.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_done,
  output logic          stall_inst,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [3:0]    data_sel,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_done,
  output logic          stall_data,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [3:0]    bus_sel,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          err,
  output logic [AW-1:0] err_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          bus_wr_q, bus_wr_d;
  logic [3:0]    bus_sel_q, bus_sel_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] inst_rdata_q, inst_rdata_d;
  logic [DW-1:0] data_rdata_q, data_rdata_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic          grant, grant_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_sel_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      bus_wr_q     <= bus_wr_d;
      bus_sel_q    <= bus_sel_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      err_addr_q   <= err_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    bus_wr_d     = bus_wr_q;
    bus_sel_d    = bus_sel_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    err_addr_d   = err_addr_q;
    grant        = 1'b0;
    grant_data   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_req) begin
          grant      = 1'b1;
          grant_data = 1'b1;
        end else if (inst_req) begin
          grant = 1'b1;
        end
      end

      ST_BUSY: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack) begin
          state_d = ST_RESP;
          tmo_d   = 1'b0;
          if (!bus_wr_q) begin
            if (owner_q == OWN_DATA) data_rdata_d = bus_rdata;
            else                     inst_rdata_d = bus_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_RESP;
          tmo_d      = 1'b1;
          err_addr_d = bus_addr_q;
          if (owner_q == OWN_DATA) data_rdata_d = '0;
          else                     inst_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RESP: begin
        // The owner's request is stale here, so only the other master may be granted.
        tmo_d = 1'b0;
        if (owner_q == OWN_INST && data_req) begin
          grant      = 1'b1;
          grant_data = 1'b1;
        end else if (owner_q == OWN_DATA && inst_req) begin
          grant = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      state_d = ST_BUSY;
      cnt_d   = '0;
      tmo_d   = 1'b0;
      if (grant_data) begin
        owner_d     = OWN_DATA;
        bus_wr_d    = data_wr;
        bus_sel_d   = data_sel;
        bus_addr_d  = data_addr;
        bus_wdata_d = data_wdata;
      end else begin
        owner_d     = OWN_INST;
        bus_wr_d    = 1'b0;
        bus_sel_d   = 4'hF;
        bus_addr_d  = inst_addr;
        bus_wdata_d = '0;
      end
    end
  end

  assign bus_req    = (state_q == ST_BUSY);
  assign bus_wr     = bus_wr_q;
  assign bus_sel    = bus_sel_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst_done  = (state_q == ST_RESP) && (owner_q == OWN_INST);
  assign data_done  = (state_q == ST_RESP) && (owner_q == OWN_DATA);
  assign err        = (state_q == ST_RESP) && tmo_q;
  assign err_addr   = err_addr_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign stall_inst = inst_req & ~inst_done;
  assign stall_data = data_req & ~data_done;

endmodule
